// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready [1:0] per-requester operation handshake; req_op*/req_a*/req_b* operation fields
//   rsp_valid/rsp_ready [1:0] per-requester result handshake; rsp_result/rsp_zero registered result
//   alu_op/alu_a/alu_b       latched operation driven to the shared ALU
//   alu_result/alu_zero      combinational ALU return
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic rr, owner, gnt, acc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = (state == IDLE) ? (acc ? EXEC : IDLE) :
                (state == EXEC) ? RESP :
                (rsp_ready[owner] ? IDLE : RESP);
  end
  // gnt is the requester index: the pointer breaks ties, otherwise the lone valid one wins
  always_comb begin
    gnt = (&req_valid) ? rr : req_valid[1];
    acc = (state == IDLE) && (|req_valid);
    req_ready = (acc && rst_n) ? {gnt, ~gnt} : 2'b00;
    rsp_valid = (state == RESP) ? {owner, ~owner} : 2'b00;
  end
  // the ALU inputs are the latched registers themselves, so they only move on an accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
      owner <= 1'b0;
      alu_op <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
    end else begin
      if (acc) begin
        owner <= gnt;
        rr <= ~gnt;
        alu_op <= gnt ? req_op1 : req_op0;
        alu_a <= gnt ? req_a1 : req_a0;
        alu_b <= gnt ? req_b1 : req_b0;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero <= alu_zero;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed self-checking bench for alu_share_arb with a behavioural ALU.
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0 = '0, req_op1 = '0;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  int          passed = 0, total = 0;

  alu_share_arb #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = alu_a + alu_b;
      3'b001: alu_result = alu_a - alu_b;
      3'b010: alu_result = alu_b << alu_a;
      3'b011: alu_result = alu_a | alu_b;
      3'b100: alu_result = alu_a & alu_b;
      3'b101: alu_result = {31'b0, alu_a < alu_b};
      3'b110: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = alu_a ^ alu_b;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // single-requester op with rsp_ready high: accept, one EXEC cycle, response, back to IDLE
  task automatic run_op(input logic idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_z);
    if (idx) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else begin req_op0 = op; req_a0 = a; req_b0 = b; end
    req_valid = idx ? 2'b10 : 2'b01;
    #1;
    chk("op_ready", {30'b0, req_ready}, {30'b0, idx, ~idx});
    step();
    req_valid = 2'b00;
    chk("op_exec_alu_a", alu_a, a);
    chk("op_exec_rspv", {30'b0, rsp_valid}, 32'd0);
    step();
    chk("op_rspv", {30'b0, rsp_valid}, {30'b0, idx, ~idx});
    chk("op_result", rsp_result, exp_res);
    chk("op_zero", {31'b0, rsp_zero}, {31'b0, exp_z});
    step();
    chk("op_done", {30'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    req_valid = 2'b11;
    #2;
    chk("rst_ready", {30'b0, req_ready}, 32'd0);
    chk("rst_rspv", {30'b0, rsp_valid}, 32'd0);
    chk("rst_alu", {29'b0, alu_op} | alu_a | alu_b, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_op(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0);
    run_op(1'b1, 3'b001, 32'd9, 32'd9, 32'd0, 1'b1);
    run_op(1'b1, 3'b010, 32'd4, 32'd1, 32'd16, 1'b0);
    run_op(1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    run_op(1'b0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    run_op(1'b0, 3'b111, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1'b0);
    // reset during EXEC discards the op
    req_op1 = 3'b000; req_a1 = 32'd100; req_b1 = 32'd1;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    chk("mid_exec_a", alu_a, 32'd100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_op", {29'b0, alu_op}, 32'd0);
    chk("mid_rst_rspv", {30'b0, rsp_valid}, 32'd0);
    chk("mid_rst_result", rsp_result, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("mid_rst_ready", {30'b0, req_ready}, 32'd0);
    step();
    step();
    chk("rst_hold_rspv", {30'b0, rsp_valid}, 32'd0);
    // contention: both valid, grants must alternate starting from requester 0
    req_op0 = 3'b000; req_a0 = 32'd3; req_b0 = 32'd4;
    req_op1 = 3'b111; req_a1 = 32'hF0; req_b1 = 32'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rspv", {30'b0, rsp_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", {30'b0, req_ready}, (k % 2) ? 32'd2 : 32'd1);
      step();
      chk("rr_exec_ready", {30'b0, req_ready}, 32'd0);
      step();
      chk("rr_rspv", {30'b0, rsp_valid}, (k % 2) ? 32'd2 : 32'd1);
      chk("rr_result", rsp_result, (k % 2) ? 32'h0F : 32'd7);
      chk("rr_resp_ready", {30'b0, req_ready}, 32'd0);
      step();
    end
    // backpressure on owner 0; rsp_ready[1] high must be ignored
    chk("bp_grant", {30'b0, req_ready}, 32'd1);
    rsp_ready = 2'b10;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rspv", {30'b0, rsp_valid}, 32'd1);
      chk("bp_result", rsp_result, 32'd7);
      chk("bp_ready", {30'b0, req_ready}, 32'd0);
      step();
    end
    rsp_ready = 2'b11;
    step();
    chk("bp_release_rspv", {30'b0, rsp_valid}, 32'd0);
    chk("bp_next_grant", {30'b0, req_ready}, 32'd2);
    req_valid = 2'b00;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
